// File: rtl/aud_trace_pkg.sv
// rtl/aud_trace_pkg.sv - shared addresses, record layout and state types for the AUD trace drain
package aud_trace_pkg;

  localparam logic [31:0] ADDR_CSR_DEF = 32'h0;
  localparam logic [31:0] ADDR_BTF_DEF = 32'h4;
  localparam logic [31:0] ADDR_BAF_DEF = 32'h8;
  localparam int unsigned FC_LSB_DEF   = 16;
  localparam int unsigned FC_WIDTH_DEF = 5;
  localparam int unsigned POLL_GAP_DEF = 16;

  localparam int unsigned REC_BAF_MSB   = 63;
  localparam int unsigned REC_BAF_LSB   = 32;
  localparam int unsigned REC_VALID_BIT = 31;
  localparam int unsigned REC_TS_MSB    = 30;
  localparam int unsigned REC_TS_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POLL   = 3'd1,
    ST_RD_BTF = 3'd2,
    ST_RD_BAF = 3'd3,
    ST_EMIT   = 3'd4,
    ST_GAP    = 3'd5
  } drain_state_e;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_STB  = 2'd1,
    WB_DATA = 2'd2
  } wb_state_e;

endpackage

// File: rtl/aud_wb_rd.sv
// rtl/aud_wb_rd.sv - single-read Wishbone master; data is taken the cycle after ack
module aud_wb_rd
  import aud_trace_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        done_o,
  output logic [31:0] data_o,
  output logic [31:0] wb_adr_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i
);

  wb_state_e   state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= WB_IDLE;
      adr_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // A level request is ignored during the done cycle so one request yields one read.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (req_i && !done_q) begin
          adr_d   = addr_i;
          state_d = WB_STB;
        end
      end
      WB_STB: begin
        if (wb_ack_i) state_d = WB_DATA;
      end
      WB_DATA: begin
        data_d  = wb_dat_i;
        done_d  = 1'b1;
        state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  assign wb_stb_o = (state_q == WB_STB);
  assign wb_adr_o = adr_q;
  assign done_o   = done_q;
  assign data_o   = data_q;

endmodule

// File: rtl/aud_trace_drain.sv
// rtl/aud_trace_drain.sv - drains AUD BTM FIFO records over Wishbone onto a valid/ready stream
// Optional AUD_TRACE_DROP_INVALID_EN drops records whose addr_valid bit is clear.
module aud_trace_drain
  import aud_trace_pkg::*;
#(
  parameter logic [31:0] ADDR_CSR = ADDR_CSR_DEF,
  parameter logic [31:0] ADDR_BTF = ADDR_BTF_DEF,
  parameter logic [31:0] ADDR_BAF = ADDR_BAF_DEF,
  parameter int unsigned FC_LSB   = FC_LSB_DEF,
  parameter int unsigned FC_WIDTH = FC_WIDTH_DEF,
  parameter int unsigned POLL_GAP = POLL_GAP_DEF
)(
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  output logic [31:0] wb_adr_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
  output logic [63:0] rec_data_o,
  output logic        rec_valid_o,
  input  logic        rec_ready_i,
  output logic [31:0] rec_count_o,
`ifdef AUD_TRACE_DROP_INVALID_EN
  output logic [31:0] skip_count_o,
`endif
  output logic        busy_o
);

  localparam logic [FC_WIDTH-1:0] REM_ONE  = {{(FC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [15:0]         GAP_LOAD = 16'(POLL_GAP);

  drain_state_e        state_q, state_d, after_rec;
  logic [FC_WIDTH-1:0] rem_q, rem_d, fc;
  logic [15:0]         gap_q, gap_d;
  logic [63:0]         rec_q, rec_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                stop_q, stop_d, stop_now;
  logic                rd_req, rd_done;
  logic [31:0]         rd_addr, rd_data;
`ifdef AUD_TRACE_DROP_INVALID_EN
  logic [31:0]         skip_q, skip_d;
`endif

  aud_wb_rd u_wb_rd (
    .clk_i   (clk_sys_i),
    .rst_n_i (rst_n_i),
    .req_i   (rd_req),
    .addr_i  (rd_addr),
    .done_o  (rd_done),
    .data_o  (rd_data),
    .wb_adr_o(wb_adr_o),
    .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i),
    .wb_dat_i(wb_dat_i)
  );

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      rec_q   <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
`ifdef AUD_TRACE_DROP_INVALID_EN
      skip_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      rec_q   <= rec_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
`ifdef AUD_TRACE_DROP_INVALID_EN
      skip_q  <= skip_d;
`endif
    end
  end

  // A disable seen anywhere in a record sequence is remembered until the record is finished.
  assign stop_now  = stop_q | ~enable_i;
  assign fc        = rd_data[FC_LSB +: FC_WIDTH];
  assign after_rec = stop_now ? ST_IDLE : ((rem_q == REM_ONE) ? ST_POLL : ST_RD_BTF);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    rec_d   = rec_q;
    cnt_d   = cnt_q;
    stop_d  = stop_now;
    rd_req  = 1'b0;
    rd_addr = ADDR_CSR;
`ifdef AUD_TRACE_DROP_INVALID_EN
    skip_d  = skip_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        rem_d  = '0;
        if (enable_i) state_d = ST_POLL;
      end
      ST_POLL: begin
        rd_req = 1'b1;
        if (rd_done) begin
          if (stop_now) begin
            state_d = ST_IDLE;
          end else if (fc == '0) begin
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            rem_d   = fc;
            state_d = ST_RD_BTF;
          end
        end
      end
      ST_RD_BTF: begin
        rd_req  = 1'b1;
        rd_addr = ADDR_BTF;
        if (rd_done) begin
          rec_d[REC_VALID_BIT]         = rd_data[31];
          rec_d[REC_TS_MSB:REC_TS_LSB] = rd_data[30:0];
          state_d                      = ST_RD_BAF;
        end
      end
      ST_RD_BAF: begin
        rd_req  = 1'b1;
        rd_addr = ADDR_BAF;
        if (rd_done) begin
          rec_d[REC_BAF_MSB:REC_BAF_LSB] = rd_data;
`ifdef AUD_TRACE_DROP_INVALID_EN
          if (!rec_q[REC_VALID_BIT]) begin
            skip_d  = skip_q + 32'd1;
            rem_d   = rem_q - REM_ONE;
            state_d = after_rec;
          end else begin
            state_d = ST_EMIT;
          end
`else
          state_d = ST_EMIT;
`endif
        end
      end
      ST_EMIT: begin
        if (rec_ready_i) begin
          cnt_d   = cnt_q + 32'd1;
          rem_d   = rem_q - REM_ONE;
          state_d = after_rec;
        end
      end
      ST_GAP: begin
        if (stop_now)             state_d = ST_IDLE;
        else if (gap_q <= 16'd1)  state_d = ST_POLL;
        else                      gap_d   = gap_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wb_we_o     = 1'b0;
  assign rec_data_o  = rec_q;
  assign rec_valid_o = (state_q == ST_EMIT);
  assign rec_count_o = cnt_q;
  assign busy_o      = (state_q != ST_IDLE);
`ifdef AUD_TRACE_DROP_INVALID_EN
  assign skip_count_o = skip_q;
`endif

endmodule

// File: doc/aud_trace_drain.md
Name: aud_trace_drain

Overview:
- Wishbone master that sits directly downstream of the AUD core's branch-trace (BTM) FIFO.
- Polls the core CSR for the BTM FIFO count, then drains that many records. Each record is two reads: BTF (timestamp plus addr_valid), then BAF (branch address; reading BAF pops the FIFO).
- Presents each 64-bit record on a valid/ready stream to the host-link packetiser.

Parameters:
- ADDR_CSR, 32'h0, CSR word address in the AUD core.
- ADDR_BTF, 32'h4, BTM timestamp word address.
- ADDR_BAF, 32'h8, BTM address word address (pop side effect).
- FC_LSB, 16, bit offset of the BTM FIFO count field in CSR.
- FC_WIDTH, 5, width of the count field (FIFO address width + 1).
- POLL_GAP, 16, idle cycles between polls that return count 0; range 1..65535.

Ports:
- clk_sys_i  in  1  system clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- enable_i  in  1  drain enable, level.
- wb_adr_o  out  32  Wishbone address.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable; always 0.
- wb_ack_i  in  1  acknowledge.
- wb_dat_i  in  32  read data; valid exactly 1 cycle after the ack cycle.
- rec_data_o  out  64  record: [63:32] = BAF, [31:0] = BTF.
- rec_valid_o  out  1  record valid.
- rec_ready_i  in  1  sink ready.
- rec_count_o  out  32  records emitted; wraps.
- busy_o  out  1  high in any state except IDLE.

Behaviour:
- Reset: applied asynchronously while rst_n_i = 0.
  - All outputs 0, state IDLE, counters 0.
  - Reset mid-transfer abandons the transfer; no recovery of a half-read record.
- Wishbone read sequence:
  - Drive wb_adr_o, assert wb_stb_o, hold both stable until a cycle with wb_ack_i = 1.
  - Deassert wb_stb_o in the cycle after the ack.
  - Capture wb_dat_i in the cycle after the ack.
  - The next strobe may assert no earlier than 2 cycles after the ack.
  - No timeout; the master waits indefinitely for ack.
- States:
  - IDLE: if enable_i = 1, go to POLL.
  - POLL: read ADDR_CSR; n = csr[FC_LSB+FC_WIDTH-1:FC_LSB].
    - n = 0: go to GAP.
    - n != 0: load the remaining counter with n, go to RD_BTF.
  - RD_BTF: read ADDR_BTF into the low half of the record holding register, go to RD_BAF.
  - RD_BAF: read ADDR_BAF into the high half, go to EMIT.
  - EMIT: rec_valid_o = 1 with rec_data_o stable until rec_valid_o & rec_ready_i.
    - On the handshake: rec_count_o + 1, remaining - 1.
    - remaining = 0: go to POLL.
    - remaining != 0: go to RD_BTF.
  - GAP: count down POLL_GAP cycles, then go to POLL.
- Order rule: BTF is always read before BAF within a record. BAF is never read without the BTF of the same record.
- Disable (enable_i falls):
  - The current record sequence completes through the EMIT handshake, then the block enters IDLE.
  - In POLL or GAP, the current bus read finishes first, then IDLE.
  - The remaining counter is discarded.
- Burst limit: at most n records per poll. Records arriving mid-burst are picked up by the next POLL.
- Counter width: remaining is FC_WIDTH bits. n = 2^(FC_WIDTH-1) (full FIFO) is legal.
- rec_count_o wraps 32'hFFFFFFFF -> 0.
- Backpressure: rec_ready_i low stalls only EMIT. No bus activity occurs while stalled.
- Simultaneous events: a handshake in the same cycle enable_i falls counts as emitted, then the block enters IDLE.

Optional Feature:
- Macro: AUD_TRACE_DROP_INVALID_EN.
- When defined:
  - A record with BTF[31] (addr_valid) = 0 is not emitted; remaining still decrements.
  - Added output skip_count_o (32, wraps, reset 0) increments per dropped record.
  - The drop decision is made in RD_BAF completion; EMIT is bypassed.
  - The BAF read still occurs, to keep the FIFO popped.
- When undefined: every record is emitted and skip_count_o is absent.

Decomposition:
- Package aud_trace_pkg holds:
  - Default register addresses, FC_LSB and FC_WIDTH defaults.
  - Record field positions: BAF [63:32], VALID bit 31, TIMESTAMP [30:0].
  - State encoding constants.
- Sub-module aud_wb_rd: single-read Wishbone master sequencer.
  - Inputs: req, addr.
  - Outputs: done pulse, 32-bit data; implements the ack + 1 data capture.
  - The top FSM instantiates it once.

Test Plan:
- Count 3 with enable high:
  - Stimulus: CSR count = 3, FIFO holds (BTF, BAF) = (32'h8000_0010, 32'h0C00_1000), (32'h8000_0020, 32'h0C00_1004), (32'h8000_0030, 32'h0C00_1008).
  - Required: 3 records 64'h0C00_1000_8000_0010 etc., in order; bus sequence CSR, BTF, BAF ×3, then CSR; rec_count_o = 3.
- Count 0 polling, POLL_GAP = 16: consecutive CSR strobes are at least 16 idle cycles apart; no BTF/BAF reads.
- Backpressure: rec_ready_i low 40 cycles during the first EMIT -> rec_data_o stable; no wb_stb_o during the stall; the record is emitted once.
- Slave ack latency 5 cycles:
  - Check the strobe and address are held for 5 cycles.
  - Check data is captured from the cycle after the ack; a wrong-cycle value of 32'hDEAD_BEEF must not appear.
- enable_i dropped after the BTF read of record 2 of 4 -> record 2 completes and is emitted; IDLE with busy_o = 0; no further reads.
- With AUD_TRACE_DROP_INVALID_EN, records BTF = 32'h0000_0005 then 32'h8000_0006:
  - Required: only the second record is emitted; skip_count_o = 1; both BAF words read.
